// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: detects a fixed PAT_W-bit pattern (MSB first) in an En-qualified serial stream
module serial_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             D,
  input  logic             En,
  output logic             Det,
  output logic [CNT_W-1:0] Cnt,
  output logic             Sat
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  typedef enum logic {FILL, ARMED} state_e;
  state_e           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d, win;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, sat_q, sat_d, match, restart;
  // next-state: shift/fill only on En edges; a match in non-overlap mode restarts the window
  always_comb begin
    win      = {sh_q[PAT_W-2:0], D};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    match    = En && (state_q == ARMED || fill_inc == FULL) && (win == PATTERN);
    restart  = match && !OVERLAP;
    sh_d     = !En ? sh_q : restart ? '0 : win;
    fill_d   = !En ? fill_q : restart ? '0 : fill_inc;
    state_d  = (fill_d == FULL) ? ARMED : FILL;
    cnt_d    = (match && !sat_q) ? cnt_q + CNT_W'(1) : cnt_q;
    sat_d    = &cnt_d;
  end
  // FSM and registered outputs, cleared asynchronously by Clr
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= FILL;
      sh_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      det_q   <= match;
      sat_q   <= sat_d;
    end
  end
  assign Det = det_q;
  assign Cnt = cnt_q;
  assign Sat = sat_q;
endmodule
